avr_mem_arbiter: RTL and testbench

AVR_MEM_ARBITER -- requirements
Module: avr_mem_arbiter

---
 rtl/avr_pkg.sv | 24 ++
 rtl/avr_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_avr_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_pkg.sv
// ============================================================================
//  Module      : avr_pkg
//  Description : Shared types and constants for the AVR memory arbiter:
//                FSM state encoding and grant identifiers.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package avr_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Grant identifiers (width of last_grant)
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

endpackage : avr_pkg

`default_nettype wire

// File: rtl/avr_mem_arbiter.sv
// ============================================================================
//  Module      : avr_mem_arbiter
//  Description : Two-requester (CPU / DMA) arbiter in front of a single-port
//                synchronous RAM. One access takes ACCESS + RESPOND; the other
//                requester is granted straight out of RESPOND, so alternating
//                traffic reaches one access every two cycles.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module avr_mem_arbiter
  import avr_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int CPU_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  // DMA requester
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic [7:0]        dma_rdata,
  output logic              dma_ack,
  // Single-port RAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  state_t r_state;
  state_t w_next_state;
  logic   r_last_grant;   // requester of the current / most recent access
  logic   w_grant;        // a new access is granted on this edge
  logic   w_grant_sel;    // which requester receives that grant

  // Next-state and grant selection; RESPOND ignores the acknowledged
  // requester's still-held req and only looks at the other side.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_sel  = r_last_grant;
    case (r_state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          w_grant      = 1'b1;
          w_grant_sel  = (CPU_PRIORITY != 0) ? GNT_CPU : ~r_last_grant;
          w_next_state = ACCESS;
        end else if (cpu_req) begin
          w_grant      = 1'b1;
          w_grant_sel  = GNT_CPU;
          w_next_state = ACCESS;
        end else if (dma_req) begin
          w_grant      = 1'b1;
          w_grant_sel  = GNT_DMA;
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        w_next_state = RESPOND;
      end
      RESPOND: begin
        if (r_last_grant == GNT_CPU) begin
          if (dma_req) begin
            w_grant      = 1'b1;
            w_grant_sel  = GNT_DMA;
            w_next_state = ACCESS;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          if (cpu_req) begin
            w_grant      = 1'b1;
            w_grant_sel  = GNT_CPU;
            w_next_state = ACCESS;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register and grant history; reset makes the CPU win the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_DMA;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_last_grant <= w_grant_sel;
      end
    end
  end

  // Latch the granted request into the RAM port; write strobe lives one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_grant) begin
        if (w_grant_sel == GNT_CPU) begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_we    <= cpu_we;
        end else begin
          mem_addr  <= dma_addr;
          mem_wdata <= dma_wdata;
          mem_we    <= dma_we;
        end
      end
    end
  end

  // Acks decode RESPOND for the owner; RAM read data lands in that same cycle
  assign cpu_ack   = (r_state == RESPOND) && (r_last_grant == GNT_CPU);
  assign dma_ack   = (r_state == RESPOND) && (r_last_grant == GNT_DMA);
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule : avr_mem_arbiter

`default_nettype wire

// File: tb/tb_avr_mem_arbiter.sv
// ============================================================================
//  Module      : tb_avr_mem_arbiter
//  Description : Scoreboard bench for avr_mem_arbiter. Two instances: dut0
//                with alternating arbitration, dut1 with CPU priority. Each
//                has its own RAM model with one-cycle read latency.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_avr_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // dut0 (CPU_PRIORITY = 0)
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [15:0] cpu_addr = 0, dma_addr = 0;
  logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
  logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_we;
  logic [15:0] mem_addr;

  // dut1 (CPU_PRIORITY = 1)
  logic        p_cpu_req = 0, p_cpu_we = 0, p_dma_req = 0, p_dma_we = 0;
  logic [15:0] p_cpu_addr = 0, p_dma_addr = 0;
  logic [7:0]  p_cpu_wdata = 0, p_dma_wdata = 0;
  logic [7:0]  p_cpu_rdata, p_dma_rdata, p_mem_wdata, p_mem_rdata;
  logic        p_cpu_ack, p_dma_ack, p_mem_we;
  logic [15:0] p_mem_addr;

  avr_mem_arbiter #(.ADDR_W(16), .CPU_PRIORITY(0)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  avr_mem_arbiter #(.ADDR_W(16), .CPU_PRIORITY(1)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(p_cpu_req), .cpu_we(p_cpu_we), .cpu_addr(p_cpu_addr), .cpu_wdata(p_cpu_wdata),
    .cpu_rdata(p_cpu_rdata), .cpu_ack(p_cpu_ack),
    .dma_req(p_dma_req), .dma_we(p_dma_we), .dma_addr(p_dma_addr), .dma_wdata(p_dma_wdata),
    .dma_rdata(p_dma_rdata), .dma_ack(p_dma_ack),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we), .mem_rdata(p_mem_rdata)
  );

  // RAM models: synchronous write, one-cycle registered read
  logic [7:0] ram0 [0:65535];
  logic [7:0] ram1 [0:65535];
  always @(posedge clock) begin
    if (mem_we === 1'b1) ram0[mem_addr] <= mem_wdata;
    mem_rdata <= ram0[mem_addr];
    if (p_mem_we === 1'b1) ram1[p_mem_addr] <= p_mem_wdata;
    p_mem_rdata <= ram1[p_mem_addr];
  end

  // Scoreboard queues
  typedef struct { int cyc; bit chk_rd; logic [7:0] rd; } ack_exp_t;
  typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_exp_t;
  ack_exp_t qa0c[$], qa0d[$], qa1c[$], qa1d[$];
  wr_exp_t  qw0[$], qw1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ack_of(input int s);
    case (s)
      0:       return cpu_ack;
      1:       return dma_ack;
      2:       return p_cpu_ack;
      default: return p_dma_ack;
    endcase
  endfunction

  task automatic push_ack(input int idx, input ack_exp_t e);
    case (idx)
      0: qa0c.push_back(e);
      1: qa0d.push_back(e);
      2: qa1c.push_back(e);
      default: qa1d.push_back(e);
    endcase
  endtask

  task automatic push_wr(input int d, input wr_exp_t e);
    if (d == 0) qw0.push_back(e);
    else        qw1.push_back(e);
  endtask

  task automatic mon_ack(input string tag, input int idx, input logic [7:0] rd);
    ack_exp_t e;
    bit have = 0;
    case (idx)
      0: if (qa0c.size() > 0) begin e = qa0c.pop_front(); have = 1; end
      1: if (qa0d.size() > 0) begin e = qa0d.pop_front(); have = 1; end
      2: if (qa1c.size() > 0) begin e = qa1c.pop_front(); have = 1; end
      default: if (qa1d.size() > 0) begin e = qa1d.pop_front(); have = 1; end
    endcase
    check({tag, " ack expected"}, {31'd0, have}, 32'd1);
    if (have) begin
      check({tag, " ack cycle"}, e.cyc, cyc);
      if (e.chk_rd) check({tag, " rdata"}, {24'd0, rd}, {24'd0, e.rd});
    end
  endtask

  task automatic mon_wr(input string tag, input int d, input logic [15:0] a, input logic [7:0] dt);
    wr_exp_t e;
    int k = -1;
    if (d == 0) begin
      foreach (qw0[i]) if (k < 0 && qw0[i].cyc == cyc) k = i;
      if (k >= 0) begin e = qw0[k]; qw0.delete(k); end
    end else begin
      foreach (qw1[i]) if (k < 0 && qw1[i].cyc == cyc) k = i;
      if (k >= 0) begin e = qw1[k]; qw1.delete(k); end
    end
    check({tag, " mem_we expected"}, {31'd0, k >= 0}, 32'd1);
    if (k >= 0) begin
      check({tag, " mem_addr"}, {16'd0, a}, {16'd0, e.addr});
      check({tag, " mem_wdata"}, {24'd0, dt}, {24'd0, e.data});
    end
  endtask

  // Monitor: every ack and every write strobe must match a queued expectation
  always @(negedge clock) begin
    if (cpu_ack === 1'b1) mon_ack("dut0 cpu", 0, cpu_rdata);
    if (dma_ack === 1'b1) mon_ack("dut0 dma", 1, dma_rdata);
    if (cpu_ack === 1'b1 || dma_ack === 1'b1)
      check("dut0 double ack", {31'd0, cpu_ack & dma_ack}, 32'd0);
    if (mem_we === 1'b1) mon_wr("dut0", 0, mem_addr, mem_wdata);
    if (p_cpu_ack === 1'b1) mon_ack("dut1 cpu", 2, p_cpu_rdata);
    if (p_dma_ack === 1'b1) mon_ack("dut1 dma", 3, p_dma_rdata);
    if (p_cpu_ack === 1'b1 || p_dma_ack === 1'b1)
      check("dut1 double ack", {31'd0, p_cpu_ack & p_dma_ack}, 32'd0);
    if (p_mem_we === 1'b1) mon_wr("dut1", 1, p_mem_addr, p_mem_wdata);
  end

  // Bounded wait for an ack; called right after a rising edge
  task automatic wait_ack(input int s, input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (ack_of(s) === 1'b1) got = 1;
    end
    check({name, " ack arrived"}, {31'd0, got}, 32'd1);
  endtask

  // One dut0 access; off = hand-computed edges from now to the ack cycle
  task automatic acc0(input bit who, input bit we, input logic [15:0] addr,
                      input logic [7:0] wd, input logic [7:0] rd, input int off,
                      input bit last);
    ack_exp_t ea;
    wr_exp_t  ew;
    ea.cyc = cyc + off; ea.chk_rd = !we; ea.rd = rd;
    push_ack(who ? 1 : 0, ea);
    if (we) begin
      ew.cyc = cyc + off - 1; ew.addr = addr; ew.data = wd;
      push_wr(0, ew);
    end
    if (!who) begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end else begin
      dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end
    wait_ack(who ? 1 : 0, who ? "dut0 dma" : "dut0 cpu");
    @(posedge clock); #1;
    if (last) begin
      if (!who) cpu_req = 0;
      else      dma_req = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  // Directed scenarios
  initial begin
    ack_exp_t ea;
    wr_exp_t  ew;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset mem_addr",  {16'd0, mem_addr},  32'd0);
    check("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset mem_we",    {31'd0, mem_we},    32'd0);
    check("reset cpu_ack",   {31'd0, cpu_ack},   32'd0);
    check("reset dma_ack",   {31'd0, dma_ack},   32'd0);
    check("reset p_mem_we",  {31'd0, p_mem_we},  32'd0);
    @(posedge clock); #1 reset = 0;

    // CPU write 0x0100 = 0x5A, then read it back
    acc0(0, 1, 16'h0100, 8'h5A, 8'h00, 2, 1);
    acc0(0, 0, 16'h0100, 8'h00, 8'h5A, 2, 1);

    // Simultaneous requests after reset: CPU first, DMA two cycles later
    do_reset();
    fork
      acc0(0, 0, 16'h0100, 8'h00, 8'h5A, 2, 1);
      acc0(1, 1, 16'h0040, 8'h99, 8'h00, 4, 1);
    join

    // Both held for 8 accesses: strict alternation, one access per 2 cycles
    fork
      begin
        acc0(0, 1, 16'h0200, 8'h11, 8'h00, 2, 0);
        acc0(0, 1, 16'h0201, 8'h22, 8'h00, 3, 0);
        acc0(0, 0, 16'h0200, 8'h00, 8'h11, 3, 0);
        acc0(0, 0, 16'h0201, 8'h00, 8'h22, 3, 1);
      end
      begin
        acc0(1, 1, 16'h0300, 8'h33, 8'h00, 4, 0);
        acc0(1, 0, 16'h0300, 8'h00, 8'h33, 3, 0);
        acc0(1, 0, 16'h0100, 8'h00, 8'h5A, 3, 0);
        acc0(1, 1, 16'h0301, 8'h44, 8'h00, 3, 1);
      end
    join

    // DMA drops req during ACCESS: ack still once, then back to IDLE
    ea.cyc = cyc + 2; ea.chk_rd = 1; ea.rd = 8'h33;
    push_ack(1, ea);
    dma_req = 1; dma_we = 0; dma_addr = 16'h0300;
    @(posedge clock); #1 dma_req = 0;
    wait_ack(1, "dut0 dma dropped-req");
    @(posedge clock); #1;
    acc0(0, 0, 16'h0201, 8'h00, 8'h22, 2, 1);

    // Reset during ACCESS of a DMA write: no ack, outputs back to reset values
    ew.cyc = cyc + 1; ew.addr = 16'h0020; ew.data = 8'h77;
    push_wr(0, ew);
    dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 8'h77;
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0; dma_req = 0; dma_we = 0;
    @(negedge clock);
    check("abort mem_we",    {31'd0, mem_we},    32'd0);
    check("abort mem_addr",  {16'd0, mem_addr},  32'd0);
    check("abort mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("abort cpu_ack",   {31'd0, cpu_ack},   32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort dma_ack", {31'd0, dma_ack}, 32'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;

    // CPU_PRIORITY=1: CPU wins from IDLE even after its own grant; DMA next
    ea.cyc = cyc + 2; ea.chk_rd = 0; ea.rd = 8'h00;
    push_ack(2, ea);
    ew.cyc = cyc + 1; ew.addr = 16'h0010; ew.data = 8'hC1;
    push_wr(1, ew);
    p_cpu_req = 1; p_cpu_we = 1; p_cpu_addr = 16'h0010; p_cpu_wdata = 8'hC1;
    wait_ack(2, "dut1 cpu first");
    @(posedge clock); #1;
    ea.cyc = cyc + 2; push_ack(2, ea);
    ew.cyc = cyc + 1; ew.addr = 16'h0011; ew.data = 8'hC2; push_wr(1, ew);
    ea.cyc = cyc + 4; push_ack(3, ea);
    ew.cyc = cyc + 3; ew.addr = 16'h0012; ew.data = 8'hD1; push_wr(1, ew);
    p_cpu_addr = 16'h0011; p_cpu_wdata = 8'hC2;
    p_dma_req = 1; p_dma_we = 1; p_dma_addr = 16'h0012; p_dma_wdata = 8'hD1;
    wait_ack(2, "dut1 cpu priority");
    @(posedge clock); #1 p_cpu_req = 0;
    wait_ack(3, "dut1 dma served");
    @(posedge clock); #1 p_dma_req = 0;

    repeat (4) @(posedge clock);
    #1;
    check("leftover expectations",
          qa0c.size() + qa0d.size() + qa1c.size() + qa1d.size() + qw0.size() + qw1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_avr_mem_arbiter

`default_nettype wire
